// File: rtl/battousai_mem_access.sv
// rtl/battousai_mem_access.sv - load/store memory access FSM with sub-word read-merge-write
module battousai_mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Instr31_0,
  input  logic [63:0] Address,
  input  logic [63:0] Store_Data,
  input  logic [63:0] Mem_Dataout,
  input  logic        Mem_Ready,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Mem_Datain,
  output logic        Mem_Rd,
  output logic        Mem_Wr,
  output logic [63:0] Dataout,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [63:0] addr_q, sdata_q, rd_q;
  logic [2:0]  f3_q;
  logic        load_q, mis_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3, off;
  logic        is_load, is_store, fault, accept;
  logic [5:0]  shift_q;
  logic [63:0] lane_mask, merged;
  logic        unused_instr;

  assign opcode       = Instr31_0[6:0];
  assign funct3       = Instr31_0[14:12];
  assign off          = Address[2:0];
  assign unused_instr = ^{Instr31_0[31:15], Instr31_0[11:7]};

  assign is_load  = (opcode == 7'd3)  && (funct3 != 3'd7);
  assign is_store = (opcode == 7'd35) && !funct3[2];
  assign accept   = (state == IDLE) && start && (is_load || is_store);

  // Alignment check; access size is encoded in funct3[1:0] for both loads and stores
  always_comb begin
    fault = 1'b0;
    case (funct3[1:0])
      2'd1:    fault = off[0];
      2'd2:    fault = |off[1:0];
      2'd3:    fault = |off;
      default: fault = 1'b0;
    endcase
  end

  assign shift_q = {addr_q[2:0], 3'b000};

  // Byte-lane mask of the pending sub-word store, before shifting into position
  always_comb begin
    lane_mask = '1;
    case (f3_q[1:0])
      2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
      2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
  end

  assign merged = (rd_q & ~(lane_mask << shift_q)) | ((sdata_q & lane_mask) << shift_q);

  // Moore outputs: everything decodes from state so reset clears them immediately
  assign busy       = (state != IDLE);
  assign Mem_Rd     = (state == READ);
  assign Mem_Wr     = (state == WRITE);
  assign done       = (state == DONE);
  assign misaligned = (state == DONE) && mis_q;
  assign Mem_Addr   = busy ? {addr_q[63:3], 3'b000} : 64'd0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault)                 state_nx = DONE;
          else if (is_load)          state_nx = READ;
          else if (funct3 == 3'd3)   state_nx = WRITE;
          else                       state_nx = READ;
        end
      end
      READ:    if (Mem_Ready) state_nx = load_q ? DONE : MERGE;
      MERGE:   state_nx = WRITE;
      WRITE:   if (Mem_Ready) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, load capture, read word capture and write-word generation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      load_q     <= 1'b0;
      mis_q      <= 1'b0;
      Dataout    <= '0;
      Mem_Datain <= '0;
    end else begin
      if (accept) begin
        addr_q  <= Address;
        sdata_q <= Store_Data;
        f3_q    <= funct3;
        load_q  <= is_load;
        mis_q   <= fault;
        if (is_store && (funct3 == 3'd3) && !fault) Mem_Datain <= Store_Data;
      end
      if ((state == READ) && Mem_Ready) begin
        if (load_q) Dataout <= Mem_Dataout >> shift_q;
        else        rd_q    <= Mem_Dataout;
      end
      if (state == MERGE) Mem_Datain <= merged;
    end
  end

endmodule

// File: tb/tb_battousai_mem_access.sv
// tb/tb_battousai_mem_access.sv - randomized self-checking bench for battousai_mem_access
module tb_battousai_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] Instr31_0;
  logic [63:0] Address, Store_Data, Mem_Dataout;
  logic        Mem_Ready;
  logic [63:0] Mem_Addr, Mem_Datain, Dataout;
  logic        Mem_Rd, Mem_Wr, busy, done, misaligned;

  battousai_mem_access dut (
    .clk(clk), .reset(reset), .start(start), .Instr31_0(Instr31_0),
    .Address(Address), .Store_Data(Store_Data), .Mem_Dataout(Mem_Dataout),
    .Mem_Ready(Mem_Ready), .Mem_Addr(Mem_Addr), .Mem_Datain(Mem_Datain),
    .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Dataout(Dataout), .busy(busy),
    .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] dmodel = 64'd0;
  logic [63:0] last_wr;
  int          last_rd_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rdmem(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h5a5a_c3c3, ~a[31:0]};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0]   = op;
    r[14:12] = f3;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // fixed_stall >= 0: stall the first fixed_stall request cycles; -1: random stalls
  task automatic do_op(input logic [31:0] instr, input logic [63:0] addr, input logic [63:0] sdata,
                       input int fixed_stall, input bit noise);
    logic [6:0]  op;
    logic [2:0]  f3;
    int          n, off, lat, stalls, rd_cyc, wr_cyc, nwr, exp_lat;
    bit          is_ld, is_st, fault, mis_seen, addr_bad, wr_unstable, got_done, stall, bad;
    logic [63:0] daddr, word, exp_word, wr_word, first_wr;
    op = instr[6:0];
    f3 = instr[14:12];
    off = int'(addr[2:0]);
    n = 1 << f3[1:0];
    daddr = {addr[63:3], 3'b000};
    word = rdmem(daddr);
    is_ld = (op == 7'd3) && (f3 != 3'd7);
    is_st = (op == 7'd35) && (f3 <= 3'd3);
    fault = (is_ld || is_st) && ((off % n) != 0);
    lat = 1; stalls = 0; rd_cyc = 0; wr_cyc = 0; nwr = 0;
    mis_seen = 0; addr_bad = 0; wr_unstable = 0; got_done = 0;
    wr_word = '0; first_wr = '0;

    Instr31_0 = instr; Address = addr; Store_Data = sdata; start = 1'b1;
    Mem_Ready = 1'($urandom_range(0, 1)); Mem_Dataout = {$urandom, $urandom};
    step();
    start = 1'b0;
    Instr31_0 = $urandom; Address = {$urandom, $urandom}; Store_Data = {$urandom, $urandom};

    if (!(is_ld || is_st)) begin
      bad = 0;
      for (int i = 0; i < 3; i++) begin
        if (busy || Mem_Rd || Mem_Wr || done) bad = 1;
        step();
      end
      chk("ignored_op", 64'(bad), 64'd0);
      chk("ignored_dout", Dataout, dmodel);
      return;
    end

    for (int c = 0; c < 60; c++) begin
      if (done) begin
        got_done = 1;
        mis_seen = misaligned;
        break;
      end
      Mem_Dataout = {$urandom, $urandom};
      if (Mem_Rd || Mem_Wr) begin
        if (Mem_Addr !== daddr) addr_bad = 1;
        if (fixed_stall >= 0) stall = (stalls < fixed_stall);
        else                  stall = (stalls < 8) && ($urandom_range(0, 2) == 0);
        Mem_Ready = !stall;
        if (stall) stalls++;
        if (Mem_Rd) begin
          rd_cyc++;
          Mem_Dataout = word;
        end
        if (Mem_Wr) begin
          if (wr_cyc == 0) first_wr = Mem_Datain;
          else if (Mem_Datain !== first_wr) wr_unstable = 1;
          wr_cyc++;
          if (!stall) begin
            nwr++;
            wr_word = Mem_Datain;
          end
        end
      end else begin
        Mem_Ready = 1'($urandom_range(0, 1));
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        Instr31_0 = mk(7'd3, 3'($urandom_range(0, 6)));
        Address = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFF8;
      end
      step();
      lat++;
    end

    // A valid start while DONE is showing must not be taken
    start = 1'b1;
    Instr31_0 = mk(7'd3, 3'd3);
    Address = 64'h0000_0000_0000_7000;
    Mem_Ready = 1'b1;
    step();
    start = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("no_start_in_done", 64'(busy), 64'd0);

    if (fault) exp_lat = 1;
    else if (is_ld || (f3 == 3'd3)) exp_lat = 2;
    else exp_lat = 4;
    chk("latency", 64'(lat), 64'(exp_lat + stalls));
    chk("misaligned", 64'(mis_seen), 64'(fault));
    last_rd_cyc = rd_cyc;

    if (fault) begin
      chk("fault_no_req", 64'(rd_cyc + wr_cyc), 64'd0);
    end else if (is_ld) begin
      chk("ld_addr", 64'(addr_bad), 64'd0);
      chk("ld_no_write", 64'(wr_cyc), 64'd0);
      dmodel = word >> (8 * off);
    end else begin
      exp_word = word;
      for (int b = 0; b < 8; b++)
        if (b >= off && b < off + n) exp_word[8*b +: 8] = sdata[8*(b-off) +: 8];
      chk("st_addr", 64'(addr_bad), 64'd0);
      chk("st_wr_count", 64'(nwr), 64'd1);
      chk("st_wr_data", wr_word, exp_word);
      chk("st_wr_stable", 64'(wr_unstable), 64'd0);
      chk("st_read_needed", 64'(rd_cyc > 0), 64'(f3 != 3'd3));
      mem[daddr] = exp_word;
      last_wr = wr_word;
    end
    chk("dataout", Dataout, dmodel);
  endtask

  initial begin
    bit bad;
    int kind;
    logic [63:0] a;
    reset = 1'b0; start = 1'b0; Instr31_0 = '0; Address = '0; Store_Data = '0;
    Mem_Dataout = '0; Mem_Ready = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done | misaligned), 64'd0);
    chk("rst_req", 64'(Mem_Rd | Mem_Wr), 64'd0);
    chk("rst_addr", Mem_Addr, 64'd0);
    chk("rst_dout", Dataout, 64'd0);
    chk("rst_datain", Mem_Datain, 64'd0);
    reset = 1'b1;

    mem[64'h1000] = 64'h8877_6655_4433_2211;
    do_op(mk(7'd3, 3'd4), 64'h1005, {$urandom, $urandom}, 0, 0);
    chk("lbu_value", Dataout, 64'h0000_0000_0088_7766);

    mem[64'h2000] = 64'h1111_1111_1111_1111;
    do_op(mk(7'd35, 3'd0), 64'h2003, 64'h0000_0000_0000_00AB, 0, 0);
    chk("sb_value", last_wr, 64'h1111_1111_AB11_1111);

    do_op(mk(7'd3, 3'd2), 64'h3002, '0, 0, 0);

    do_op(mk(7'd3, 3'd3), 64'h4000, '0, 3, 1);
    chk("ld_rd_cycles", 64'(last_rd_cyc), 64'd4);

    // Reset in the middle of a stalled sd write
    Instr31_0 = mk(7'd35, 3'd3); Address = 64'h5000; Store_Data = 64'hCAFE_F00D_1234_5678;
    start = 1'b1; Mem_Ready = 1'b0;
    step();
    start = 1'b0;
    chk("sd_in_write", 64'(Mem_Wr), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_mid_wr", 64'(Mem_Wr), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_addr", Mem_Addr, 64'd0);
    chk("rst_mid_datain", Mem_Datain, 64'd0);
    dmodel = 64'd0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    Mem_Ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) bad = 1;
    end
    chk("no_done_after_rst", 64'(bad), 64'd0);
    do_op(mk(7'd3, 3'd0), 64'h1007, '0, 0, 0);

    do_op(mk(7'd51, 3'd0), 64'h1000, '0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 19);
      a = 64'h6000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
      if (kind < 9)
        do_op(mk(7'd3, 3'($urandom_range(0, 6))), a, {$urandom, $urandom}, -1, 1'($urandom_range(0, 1)));
      else if (kind < 18)
        do_op(mk(7'd35, 3'($urandom_range(0, 3))), a, {$urandom, $urandom}, -1, 1'($urandom_range(0, 1)));
      else if (kind == 18)
        do_op(mk(7'd3, 3'd7), a, '0, -1, 0);
      else
        do_op(mk(7'd35, 3'($urandom_range(4, 7))), a, '0, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
